// File: rtl/hazard_forward_ctrl.sv
// Forwarding/hazard control for the 5-stage RV32IM pipeline: registered EXE operand selects (1 cycle),
// combinational STALL for load-use, divider RAW/WAW and divider structural hazards; no handshake, STALL is the only backpressure.
module hazard_forward_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int MDIV_LAT = 32,
  parameter int CNT_W    = 6
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              ID_VALID,
  input  logic [ADDR_W-1:0] ID_ADDR1,
  input  logic [ADDR_W-1:0] ID_ADDR2,
  input  logic              ID_USE1,
  input  logic              ID_USE2,
  input  logic [ADDR_W-1:0] ID_RD,
  input  logic              ID_WE,
  input  logic              ID_MDIV,
  input  logic [ADDR_W-1:0] EXE_ADDR,
  input  logic              EXE_WE,
  input  logic              EXE_LOAD,
  input  logic              EXE_MDIV,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_WE,
  input  logic [ADDR_W-1:0] WB_ADDR,
  input  logic              WB_WE,
  input  logic              FLUSH,
  output logic [1:0]        DATA1EXESEL,
  output logic [1:0]        DATA2EXESEL,
  output logic              STALL,
  output logic              MDIV_BUSY,
  output logic [ADDR_W-1:0] MDIV_RD
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [1:0] SEL_RF   = 2'b00;
  localparam logic [1:0] SEL_WB   = 2'b01;
  localparam logic [1:0] SEL_MEM  = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDIV_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mdiv_rd_q, mdiv_rd_d;
  logic [1:0]        sel1_q, sel1_d;
  logic [1:0]        sel2_q, sel2_d;

  logic src1_nz, src2_nz;
  logic exe_hit1, exe_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic in_busy, in_drain;
  logic load_use, div_raw, div_waw, div_struct;
  logic stall;
  logic div_issue;

  // x0 is never a real producer, so it must never forward or stall.
  assign src1_nz  = (ID_ADDR1 != '0);
  assign src2_nz  = (ID_ADDR2 != '0);

  assign exe_hit1 = EXE_WE & (EXE_ADDR == ID_ADDR1) & src1_nz;
  assign exe_hit2 = EXE_WE & (EXE_ADDR == ID_ADDR2) & src2_nz;
  assign mem_hit1 = MEM_WE & (MEM_ADDR == ID_ADDR1) & src1_nz;
  assign mem_hit2 = MEM_WE & (MEM_ADDR == ID_ADDR2) & src2_nz;
  assign wb_hit1  = WB_WE  & (WB_ADDR  == ID_ADDR1) & src1_nz;
  assign wb_hit2  = WB_WE  & (WB_ADDR  == ID_ADDR2) & src2_nz;

  assign in_busy  = (state_q == S_BUSY);
  assign in_drain = (state_q == S_DRAIN);

  // A load in EXE has no data until MEM, so the consumer waits one cycle and then forwards from MEM.
  assign load_use   = EXE_LOAD & ((ID_USE1 & exe_hit1) | (ID_USE2 & exe_hit2));
  assign div_raw    = in_busy & ((ID_USE1 & (ID_ADDR1 == mdiv_rd_q)) |
                                 (ID_USE2 & (ID_ADDR2 == mdiv_rd_q)));
  assign div_waw    = in_busy & ID_WE & (ID_RD == mdiv_rd_q);
  assign div_struct = ID_MDIV & (in_busy | in_drain);

  assign stall = ID_VALID & (load_use | div_raw | div_waw | div_struct);

  assign div_issue = EXE_MDIV & EXE_WE & (EXE_ADDR != '0);

  always_comb begin
    sel1_d = SEL_RF;
    sel2_d = SEL_RF;
    if (ID_VALID && !stall && !FLUSH) begin
      if (ID_USE1) begin
        if (exe_hit1)      sel1_d = SEL_MEM;
        else if (mem_hit1) sel1_d = SEL_WB;
        else if (wb_hit1)  sel1_d = SEL_HOLD;
      end
      if (ID_USE2) begin
        if (exe_hit2)      sel2_d = SEL_MEM;
        else if (mem_hit2) sel2_d = SEL_WB;
        else if (wb_hit2)  sel2_d = SEL_HOLD;
      end
    end
  end

  // DRAIN covers the WB cycle of the divide result; the consumer then picks it up via WB-hold.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mdiv_rd_d = mdiv_rd_q;
    case (state_q)
      S_IDLE: begin
        if (div_issue) begin
          state_d   = S_BUSY;
          cnt_d     = CNT_INIT;
          mdiv_rd_d = EXE_ADDR;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) state_d = S_DRAIN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mdiv_rd_q <= '0;
      sel1_q    <= SEL_RF;
      sel2_q    <= SEL_RF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mdiv_rd_q <= mdiv_rd_d;
      sel1_q    <= sel1_d;
      sel2_q    <= sel2_d;
    end
  end

  assign DATA1EXESEL = sel1_q;
  assign DATA2EXESEL = sel2_q;
  assign STALL       = stall;
  assign MDIV_BUSY   = in_busy | in_drain;
  assign MDIV_RD     = mdiv_rd_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_hazard_forward_ctrl;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       ID_VALID, ID_USE1, ID_USE2, ID_WE, ID_MDIV;
  logic [4:0] ID_ADDR1, ID_ADDR2, ID_RD;
  logic [4:0] EXE_ADDR, MEM_ADDR, WB_ADDR;
  logic       EXE_WE, EXE_LOAD, EXE_MDIV, MEM_WE, WB_WE, FLUSH;
  logic [1:0] DATA1EXESEL, DATA2EXESEL;
  logic       STALL, MDIV_BUSY;
  logic [4:0] MDIV_RD;

  typedef struct {
    string      name;
    logic [3:0] m;    // which fields to compare: sel1, sel2, stall, busy
    logic [1:0] s1;
    logic [1:0] s2;
    logic       st;
    logic       bz;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  hazard_forward_ctrl #(.ADDR_W(5), .MDIV_LAT(32), .CNT_W(6)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .ID_VALID(ID_VALID), .ID_ADDR1(ID_ADDR1), .ID_ADDR2(ID_ADDR2),
    .ID_USE1(ID_USE1), .ID_USE2(ID_USE2), .ID_RD(ID_RD), .ID_WE(ID_WE), .ID_MDIV(ID_MDIV),
    .EXE_ADDR(EXE_ADDR), .EXE_WE(EXE_WE), .EXE_LOAD(EXE_LOAD), .EXE_MDIV(EXE_MDIV),
    .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .WB_ADDR(WB_ADDR), .WB_WE(WB_WE),
    .FLUSH(FLUSH),
    .DATA1EXESEL(DATA1EXESEL), .DATA2EXESEL(DATA2EXESEL),
    .STALL(STALL), .MDIV_BUSY(MDIV_BUSY), .MDIV_RD(MDIV_RD)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    ID_VALID = 0; ID_USE1 = 0; ID_USE2 = 0; ID_WE = 0; ID_MDIV = 0;
    ID_ADDR1 = 0; ID_ADDR2 = 0; ID_RD = 0;
    EXE_ADDR = 0; EXE_WE = 0; EXE_LOAD = 0; EXE_MDIV = 0;
    MEM_ADDR = 0; MEM_WE = 0; WB_ADDR = 0; WB_WE = 0; FLUSH = 0;
  endtask

  task automatic expect_out(input string n, input logic [3:0] m, input logic [1:0] s1,
                            input logic [1:0] s2, input logic st, input logic bz);
    exp_t e;
    e.name = n; e.m = m; e.s1 = s1; e.s2 = s2; e.st = st; e.bz = bz;
    exp_q.push_back(e);
  endtask

  // Outputs are sampled mid-cycle, after the stimulus for that cycle has settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.m[3]) begin
          checks++;
          if (DATA1EXESEL !== e.s1) begin
            failures++;
            $display("FAIL %s sel1 got=%b exp=%b", e.name, DATA1EXESEL, e.s1);
          end
        end
        if (e.m[2]) begin
          checks++;
          if (DATA2EXESEL !== e.s2) begin
            failures++;
            $display("FAIL %s sel2 got=%b exp=%b", e.name, DATA2EXESEL, e.s2);
          end
        end
        if (e.m[1]) begin
          checks++;
          if (STALL !== e.st) begin
            failures++;
            $display("FAIL %s stall got=%b exp=%b", e.name, STALL, e.st);
          end
        end
        if (e.m[0]) begin
          checks++;
          if (MDIV_BUSY !== e.bz) begin
            failures++;
            $display("FAIL %s busy got=%b exp=%b", e.name, MDIV_BUSY, e.bz);
          end
        end
      end
    end
  end

  initial begin
    RESETN = 0;
    clr();
    #1;
    expect_out("reset", 4'hF, 2'b00, 2'b00, 0, 0);
    tick(); tick();
    RESETN = 1;
    tick();

    // EXE producer forwarding
    EXE_WE = 1; EXE_ADDR = 5; ID_VALID = 1; ID_USE1 = 1; ID_ADDR1 = 5;
    expect_out("exe_fwd_nostall", 4'hF, 2'b00, 2'b00, 0, 0);
    tick();
    clr();
    EXE_WE = 1; EXE_ADDR = 7; MEM_WE = 1; MEM_ADDR = 7; WB_WE = 1; WB_ADDR = 7;
    ID_VALID = 1; ID_USE1 = 1; ID_ADDR1 = 5; ID_USE2 = 1; ID_ADDR2 = 7;
    expect_out("exe_fwd_sel", 4'hE, 2'b10, 2'b00, 0, 0);
    tick();
    // priority result; now x0 source and MEM hit on rs1
    EXE_ADDR = 0; ID_ADDR2 = 0; ID_ADDR1 = 7;
    expect_out("exe_priority", 4'hE, 2'b00, 2'b10, 0, 0);
    tick();
    // WB-only hit on rs1, unused rs2 that would hit WB
    EXE_WE = 0; MEM_WE = 0; ID_USE2 = 0; ID_ADDR2 = 7;
    expect_out("x0_and_mem", 4'hE, 2'b01, 2'b00, 0, 0);
    tick();
    clr();
    expect_out("wb_hold_unused", 4'hE, 2'b11, 2'b00, 0, 0);
    tick();

    // Load-use
    EXE_LOAD = 1; EXE_WE = 1; EXE_ADDR = 3; ID_VALID = 1; ID_USE2 = 1; ID_ADDR2 = 3;
    expect_out("load_use_stall", 4'hF, 2'b00, 2'b00, 1, 0);
    tick();
    EXE_LOAD = 0; EXE_WE = 0; EXE_ADDR = 0; MEM_WE = 1; MEM_ADDR = 3;
    expect_out("load_use_release", 4'hE, 2'b00, 2'b00, 0, 0);
    tick();
    clr();
    expect_out("load_use_mem_fwd", 4'hE, 2'b00, 2'b01, 0, 0);
    tick();

    // Divide to x9, consumer waits 32 cycles, busy for 33
    EXE_MDIV = 1; EXE_WE = 1; EXE_ADDR = 9;
    expect_out("div_issue", 4'h3, 2'b00, 2'b00, 0, 0);
    tick();
    clr();
    ID_VALID = 1; ID_USE1 = 1; ID_ADDR1 = 9;
    for (int i = 0; i < 32; i++) begin
      expect_out($sformatf("div_raw_c%0d", i), 4'hF, 2'b00, 2'b00, 1, 1);
      tick();
    end
    WB_WE = 1; WB_ADDR = 9;
    expect_out("div_drain", 4'h3, 2'b00, 2'b00, 0, 1);
    tick();
    clr();
    expect_out("div_done", 4'hB, 2'b11, 2'b00, 0, 0);
    tick();

    // Second divide: structural, WAW, independent, FLUSH
    EXE_MDIV = 1; EXE_WE = 1; EXE_ADDR = 9;
    tick();
    clr();
    ID_VALID = 1; ID_MDIV = 1;
    expect_out("busy_struct", 4'h3, 2'b00, 2'b00, 1, 1);
    tick();
    ID_MDIV = 0; ID_WE = 1; ID_RD = 9;
    expect_out("busy_waw", 4'h3, 2'b00, 2'b00, 1, 1);
    tick();
    ID_WE = 0; ID_RD = 0; ID_USE1 = 1; ID_ADDR1 = 4; MEM_WE = 1; MEM_ADDR = 4;
    expect_out("busy_indep", 4'h3, 2'b00, 2'b00, 0, 1);
    tick();
    FLUSH = 1;
    expect_out("busy_indep_sel", 4'hB, 2'b01, 2'b00, 0, 1);
    tick();
    clr();
    ID_VALID = 1; ID_MDIV = 1; FLUSH = 1;
    expect_out("flush_clears", 4'hF, 2'b00, 2'b00, 1, 1);
    tick();
    clr();
    for (int i = 0; i < 27; i++) tick();
    ID_VALID = 1; ID_MDIV = 1;
    expect_out("flush_div_drain", 4'h3, 2'b00, 2'b00, 1, 1);
    tick();
    expect_out("flush_div_idle", 4'h3, 2'b00, 2'b00, 0, 0);
    tick();
    clr();

    // Reset mid-divide
    EXE_MDIV = 1; EXE_WE = 1; EXE_ADDR = 9;
    tick();
    clr();
    ID_VALID = 1; ID_USE1 = 1; ID_ADDR1 = 4; MEM_WE = 1; MEM_ADDR = 4;
    expect_out("rst_pre_busy", 4'h3, 2'b00, 2'b00, 0, 1);
    tick();
    expect_out("rst_pre_sel", 4'h9, 2'b01, 2'b00, 0, 1);
    tick();
    #1;
    RESETN = 0;
    ID_ADDR1 = 9;
    expect_out("rst_mid_busy", 4'hF, 2'b00, 2'b00, 0, 0);
    tick();
    RESETN = 1;
    clr();
    expect_out("rst_after", 4'hF, 2'b00, 2'b00, 0, 0);
    tick();
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
